bcd_to_binary_14: RTL and testbench

Sequential BCD-to-binary converter. It is the inverse of the 14-bit binary-to-BCD block: five BCD digits (ten-thousands digit limited to 2 bits) in, 14-bit unsigned binary out. It uses a multi-cycle multiply-by-10 accumulate with a start/done handshake. It sits between digit entry/display logic and datapath blocks that consume binary values.

---
 rtl/bcd_to_binary_14_if.sv | 33 +++
 rtl/bcd_to_binary_14.sv | 153 +++++++++++++++
 tb/tb_bcd_to_binary_14.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_14_if.sv
// Handshake and data bundle for bcd_to_binary_14.
//   start        : conversion request (driven by master)
//   TEN_THOUSAND : BCD ten-thousands digit, 0-3 (driven by master)
//   THOUSAND     : BCD thousands digit (driven by master)
//   HUNDREDS     : BCD hundreds digit (driven by master)
//   TENS         : BCD tens digit (driven by master)
//   ONES         : BCD ones digit (driven by master)
//   binary       : 14-bit converted value (driven by slave)
//   busy         : conversion in progress (driven by slave)
//   done         : one-cycle completion pulse (driven by slave)
//   error        : invalid digit or overflow on last conversion (driven by slave)
interface bcd_to_binary_14_if;
    logic        start;
    logic [1:0]  TEN_THOUSAND;
    logic [3:0]  THOUSAND;
    logic [3:0]  HUNDREDS;
    logic [3:0]  TENS;
    logic [3:0]  ONES;
    logic [13:0] binary;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, TEN_THOUSAND, THOUSAND, HUNDREDS, TENS, ONES,
        input  binary, busy, done, error
    );

    modport slave (
        input  start, TEN_THOUSAND, THOUSAND, HUNDREDS, TENS, ONES,
        output binary, busy, done, error
    );
endinterface

// File: rtl/bcd_to_binary_14.sv
// Sequential BCD-to-binary converter: five latched BCD digits are folded into
// a 16-bit accumulator with one multiply-by-10-and-add per cycle, then the
// result is range-checked against the 14-bit output.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : slave side of bcd_to_binary_14_if (start/digits in,
//         binary/busy/done/error out, all outputs registered)
module bcd_to_binary_14 (
    input  logic              clk,
    input  logic              rst,
    bcd_to_binary_14_if.slave bus
);
    localparam int unsigned N_DIGITS = 5;
    localparam int unsigned OUT_W    = 14;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned DIG_W    = 4;
    localparam int unsigned CNT_W    = 3;

    localparam logic [ACC_W-1:0] MAX_VAL  = ACC_W'(16383);
    localparam logic [DIG_W-1:0] MAX_DIG  = DIG_W'(9);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                          r_state;
    logic [ACC_W-1:0]                r_acc;
    logic [CNT_W-1:0]                r_cnt;
    logic [N_DIGITS-1:0][DIG_W-1:0]  r_dig;
    logic                            r_pend_err;
    logic [OUT_W-1:0]                r_binary;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_error;

    state_t                          w_state_n;
    logic [ACC_W-1:0]                w_acc_n;
    logic [CNT_W-1:0]                w_cnt_n;
    logic [N_DIGITS-1:0][DIG_W-1:0]  w_dig_n;
    logic                            w_pend_err_n;
    logic [OUT_W-1:0]                w_binary_n;
    logic                            w_busy_n;
    logic                            w_done_n;
    logic                            w_error_n;

    logic                            w_in_bad;
    logic [DIG_W-1:0]                w_cur_dig;
    logic [ACC_W-1:0]                w_acc_x10;

    // Any 4-bit input digit above 9 invalidates the whole conversion.
    assign w_in_bad = (bus.THOUSAND > MAX_DIG) || (bus.HUNDREDS > MAX_DIG) ||
                      (bus.TENS     > MAX_DIG) || (bus.ONES     > MAX_DIG);

    // Digit slot 4 holds ten-thousands so the fold runs most-significant first.
    always_comb begin
        w_cur_dig = '0;
        case (r_cnt)
            3'd0:    w_cur_dig = r_dig[4];
            3'd1:    w_cur_dig = r_dig[3];
            3'd2:    w_cur_dig = r_dig[2];
            3'd3:    w_cur_dig = r_dig[1];
            3'd4:    w_cur_dig = r_dig[0];
            default: w_cur_dig = '0;
        endcase
    end

    // acc*10 as shift-and-add; 16 bits cannot wrap for inputs up to 39999.
    assign w_acc_x10 = (r_acc << 3) + (r_acc << 1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_n    = r_state;
        w_acc_n      = r_acc;
        w_cnt_n      = r_cnt;
        w_dig_n      = r_dig;
        w_pend_err_n = r_pend_err;
        w_binary_n   = r_binary;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_error_n    = r_error;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_dig_n      = {DIG_W'(bus.TEN_THOUSAND), bus.THOUSAND,
                                    bus.HUNDREDS, bus.TENS, bus.ONES};
                    w_acc_n      = '0;
                    w_cnt_n      = '0;
                    w_busy_n     = 1'b1;
                    w_pend_err_n = w_in_bad;
                    // Bad digits skip the fold and report straight away.
                    w_state_n    = w_in_bad ? S_FINISH : S_CONV;
                end
            end
            S_CONV: begin
                w_acc_n = w_acc_x10 + ACC_W'(w_cur_dig);
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_state_n = S_FINISH;
                end
            end
            S_FINISH: begin
                if (r_pend_err || (r_acc > MAX_VAL)) begin
                    w_binary_n = '0;
                    w_error_n  = 1'b1;
                end else begin
                    w_binary_n = r_acc[OUT_W-1:0];
                    w_error_n  = 1'b0;
                end
                w_done_n  = 1'b1;
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_dig      <= '0;
            r_pend_err <= 1'b0;
            r_binary   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_acc      <= w_acc_n;
            r_cnt      <= w_cnt_n;
            r_dig      <= w_dig_n;
            r_pend_err <= w_pend_err_n;
            r_binary   <= w_binary_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_error    <= w_error_n;
        end
    end

    assign bus.binary = r_binary;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.error  = r_error;
endmodule

// File: tb/tb_bcd_to_binary_14.sv
// Directed testbench for bcd_to_binary_14 with hand-computed expectations.
module tb_bcd_to_binary_14;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    bcd_to_binary_14_if bus();

    bcd_to_binary_14 dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] tt, input logic [3:0] th,
                              input logic [3:0] hu, input logic [3:0] te,
                              input logic [3:0] on);
        bus.TEN_THOUSAND = tt[1:0];
        bus.THOUSAND     = th;
        bus.HUNDREDS     = hu;
        bus.TENS         = te;
        bus.ONES         = on;
    endtask

    // Pulse start for one edge (E0), then wait up to 20 edges for done.
    // lat = edges after E0 until done seen, -1 if it never came.
    task automatic run_conv(input logic [3:0] tt, input logic [3:0] th,
                            input logic [3:0] hu, input logic [3:0] te,
                            input logic [3:0] on, output int lat,
                            output logic [13:0] b, output logic e);
        set_digits(tt, th, hu, te, on);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        b = bus.binary;
        e = bus.error;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #12;
        n_cmp++;
        if ({bus.binary, bus.busy, bus.done, bus.error} !== 17'd0) begin
            $display("FAIL reset_outputs got %h exp 0",
                     {bus.binary, bus.busy, bus.done, bus.error});
            n_bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int busy_bad;
        int done_early;
        busy_bad   = 0;
        done_early = 0;
        set_digits(4'd1, 4'd1, 4'd7, 4'd0, 4'd4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_bad++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done !== 1'b0) done_early++;
        end
        n_cmp++;
        if (busy_bad != 0) begin
            $display("FAIL basic_busy_window got %0d low cycles exp 0", busy_bad);
            n_bad++;
        end
        n_cmp++;
        if (done_early != 0) begin
            $display("FAIL basic_done_early got %0d early pulses exp 0", done_early);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b1) begin
            $display("FAIL basic_done_e6 got %b exp 1", bus.done);
            n_bad++;
        end
        n_cmp++;
        if (bus.binary !== 14'd11704) begin
            $display("FAIL basic_value got %0d exp 11704", bus.binary);
            n_bad++;
        end
        n_cmp++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL basic_err_busy got err=%b busy=%b exp 0 0", bus.error, bus.busy);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.binary !== 14'd11704) begin
            $display("FAIL basic_hold got done=%b bin=%0d exp 0 11704", bus.done, bus.binary);
            n_bad++;
        end
    endtask

    task automatic test_values();
        int lat;
        logic [13:0] b;
        logic e;
        run_conv(4'd0, 4'd0, 4'd2, 4'd4, 4'd8, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd248 || e !== 1'b0) begin
            $display("FAIL value_248 got lat=%0d bin=%0d err=%b exp 6 248 0", lat, b, e);
            n_bad++;
        end
        run_conv(4'd0, 4'd0, 4'd0, 4'd1, 4'd5, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd15 || e !== 1'b0) begin
            $display("FAIL value_15 got lat=%0d bin=%0d err=%b exp 6 15 0", lat, b, e);
            n_bad++;
        end
        run_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd0 || e !== 1'b0) begin
            $display("FAIL value_zero got lat=%0d bin=%0d err=%b exp 6 0 0", lat, b, e);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int first_at;
        int second_at;
        int n_done;
        first_at  = -1;
        second_at = -1;
        n_done    = 0;
        set_digits(4'd0, 4'd0, 4'd2, 4'd4, 4'd8);
        bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                n_done++;
                if (n_done == 1) first_at = i;
                if (n_done == 2) begin
                    second_at = i;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (n_done != 2 || (second_at - first_at) != 7) begin
            $display("FAIL b2b_spacing got n=%0d gap=%0d exp 2 7", n_done, second_at - first_at);
            n_bad++;
        end
        n_cmp++;
        if (bus.binary !== 14'd248) begin
            $display("FAIL b2b_value got %0d exp 248", bus.binary);
            n_bad++;
        end
        repeat (3) tick();
    endtask

    task automatic test_boundary();
        int lat;
        logic [13:0] b;
        logic e;
        run_conv(4'd1, 4'd6, 4'd3, 4'd8, 4'd3, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'h3FFF || e !== 1'b0) begin
            $display("FAIL bound_16383 got lat=%0d bin=%0d err=%b exp 6 16383 0", lat, b, e);
            n_bad++;
        end
        run_conv(4'd1, 4'd6, 4'd3, 4'd8, 4'd4, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd0 || e !== 1'b1) begin
            $display("FAIL bound_16384 got lat=%0d bin=%0d err=%b exp 6 0 1", lat, b, e);
            n_bad++;
        end
        run_conv(4'd3, 4'd9, 4'd9, 4'd9, 4'd9, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd0 || e !== 1'b1) begin
            $display("FAIL bound_39999 got lat=%0d bin=%0d err=%b exp 6 0 1", lat, b, e);
            n_bad++;
        end
    endtask

    task automatic test_invalid();
        int lat;
        logic [13:0] b;
        logic e;
        run_conv(4'd0, 4'd0, 4'd0, 4'hA, 4'd0, lat, b, e);
        n_cmp++;
        if (lat != 1 || b !== 14'd0 || e !== 1'b1) begin
            $display("FAIL invalid_tens got lat=%0d bin=%0d err=%b exp 1 0 1", lat, b, e);
            n_bad++;
        end
        run_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd9, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd9 || e !== 1'b0) begin
            $display("FAIL invalid_recover got lat=%0d bin=%0d err=%b exp 6 9 0", lat, b, e);
            n_bad++;
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        logic [13:0] b;
        n_done = 0;
        b      = '0;
        set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        bus.start = 1'b1;
        tick();
        set_digits(4'd3, 4'd9, 4'd9, 4'd9, 4'd9);
        for (int i = 1; i <= 14; i++) begin
            bus.start = (i == 2 || i == 3 || i == 6) ? 1'b1 : 1'b0;
            tick();
            if (bus.done === 1'b1) begin
                n_done++;
                b = bus.binary;
            end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (n_done != 1) begin
            $display("FAIL ignore_done_count got %0d exp 1", n_done);
            n_bad++;
        end
        n_cmp++;
        if (b !== 14'd1234 || bus.busy !== 1'b0) begin
            $display("FAIL ignore_latched got bin=%0d busy=%b exp 1234 0", b, bus.busy);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        int lat;
        logic [13:0] b;
        logic e;
        n_done = 0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.binary, bus.busy, bus.done, bus.error} !== 17'd0) begin
            $display("FAIL midreset_async got %h exp 0",
                     {bus.binary, bus.busy, bus.done, bus.error});
            n_bad++;
        end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0 || bus.busy !== 1'b0) begin
            $display("FAIL midreset_no_done got n=%0d busy=%b exp 0 0", n_done, bus.busy);
            n_bad++;
        end
        run_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, lat, b, e);
        n_cmp++;
        if (lat != 6 || b !== 14'd7 || e !== 1'b0) begin
            $display("FAIL midreset_fresh got lat=%0d bin=%0d err=%b exp 6 7 0", lat, b, e);
            n_bad++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_boundary();
        test_invalid();
        test_ignore_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end
endmodule
